// File: rtl/axi_reg_responder.sv
// axi_reg_responder: AXI3/4 responder over a bank of NUM_REGS 32-bit config registers.
// Ports: regACLK/regARESETn clock and async active-low reset; AR/R read channels; AW/W/B write channels.
// Read and write engines are independent, each with one outstanding burst. Optional macro
// AXI_REG_RESPONDER_SLVERR_EN reports SLVERR for out-of-range beats and WLAST/length mismatches.
module axi_reg_responder #(
   parameter int NUM_REGS = 64
) (
   input  logic        regACLK,
   input  logic        regARESETn,
   // read address
   input  logic [14:0] regARADDR,
   input  logic [5:0]  regARID,
   input  logic [7:0]  regARLEN,
   input  logic [2:0]  regARSIZE,
   input  logic [1:0]  regARBURST,
   input  logic        regARVALID,
   output logic        regARREADY,
   // read data
   output logic [31:0] regRDATA,
   output logic [5:0]  regRID,
   output logic [1:0]  regRRESP,
   output logic        regRLAST,
   output logic        regRVALID,
   input  logic        regRREADY,
   // write address
   input  logic [14:0] regAWADDR,
   input  logic [5:0]  regAWID,
   input  logic [7:0]  regAWLEN,
   input  logic [2:0]  regAWSIZE,
   input  logic [1:0]  regAWBURST,
   input  logic        regAWVALID,
   output logic        regAWREADY,
   // write data
   input  logic [31:0] regWDATA,
   input  logic [3:0]  regWSTRB,
   input  logic        regWLAST,
   input  logic        regWVALID,
   output logic        regWREADY,
   // write response
   output logic [5:0]  regBID,
   output logic [1:0]  regBRESP,
   output logic        regBVALID,
   input  logic        regBREADY
);

   localparam int          IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [12:0] NUM_REGS_IDX = 13'(NUM_REGS);
   localparam logic [1:0]  BURST_FIXED  = 2'b00;
   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;

   typedef enum logic       {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   // Word index step: FIXED holds, INCR/WRAP count up and stick at the top index.
   function automatic logic [12:0] next_idx(input logic [12:0] idx, input logic [1:0] burst);
      if (burst == BURST_FIXED || idx == 13'h1FFF) return idx;
      return idx + 13'd1;
   endfunction

   logic [31:0] regs [NUM_REGS];

   // Address-ready is held low until the first clock after reset release, so every
   // output reads 0 while reset is asserted even though both FSMs sit in idle.
   logic ready_en;

   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) ready_en <= 1'b0;
      else             ready_en <= 1'b1;
   end

   // ------------------------------------------------------------------ read engine
   r_state_t    r_state, r_state_nxt;
   logic        ar_fire, r_fire, rd_last;
   logic [5:0]  rd_id;
   logic [7:0]  rd_len, rd_cnt;
   logic [1:0]  rd_burst;
   logic [12:0] rd_idx;
   logic [31:0] rd_dat;
   logic [1:0]  rd_resp;
   logic [12:0] rd_load_idx;
   logic        rd_load_oor;
   logic [31:0] rd_load_dat;
   logic [1:0]  rd_load_resp;

   assign ar_fire = regARVALID && regARREADY;
   assign r_fire  = regRVALID && regRREADY;
   assign rd_last = (rd_cnt == rd_len);

   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) r_state <= R_IDLE;
      else             r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
         R_DATA:  if (r_fire && rd_last) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      regARREADY = 1'b0;
      regRVALID  = 1'b0;
      regRLAST   = 1'b0;
      case (r_state)
         R_IDLE: regARREADY = ready_en;
         R_DATA: begin
            regRVALID = 1'b1;
            regRLAST  = rd_last;
         end
         default: ;
      endcase
   end

   // Beat data is captured into a register when the beat is loaded, so it stays
   // stable through RREADY stalls; a write landing at the same edge is seen by the
   // next load, not this one.
   always_comb begin
      rd_load_idx = ar_fire ? regARADDR[14:2] : next_idx(rd_idx, rd_burst);
      rd_load_oor = !(rd_load_idx < NUM_REGS_IDX);
      rd_load_dat = rd_load_oor ? 32'h0 : regs[rd_load_idx[IW-1:0]];
   end

   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) begin
         rd_id    <= '0;
         rd_len   <= '0;
         rd_cnt   <= '0;
         rd_burst <= '0;
         rd_idx   <= '0;
         rd_dat   <= '0;
         rd_resp  <= RESP_OKAY;
      end else if (ar_fire) begin
         rd_id    <= regARID;
         rd_len   <= regARLEN;
         rd_cnt   <= '0;
         rd_burst <= regARBURST;
         rd_idx   <= rd_load_idx;
         rd_dat   <= rd_load_dat;
         rd_resp  <= rd_load_resp;
      end else if (r_fire && !rd_last) begin
         rd_cnt   <= rd_cnt + 8'd1;
         rd_idx   <= rd_load_idx;
         rd_dat   <= rd_load_dat;
         rd_resp  <= rd_load_resp;
      end
   end

   assign regRDATA = rd_dat;
   assign regRID   = rd_id;
   assign regRRESP = rd_resp;

   // ------------------------------------------------------------------ write engine
   w_state_t    w_state, w_state_nxt;
   logic        aw_fire, w_fire, b_fire, wr_last;
   logic [5:0]  wr_id;
   logic [7:0]  wr_len, wr_cnt;
   logic [1:0]  wr_burst;
   logic [12:0] wr_idx;
   logic        wr_oor, wr_beat_err, wr_err;
   logic [1:0]  wr_resp;

   assign aw_fire = regAWVALID && regAWREADY;
   assign w_fire  = regWVALID && regWREADY;
   assign b_fire  = regBVALID && regBREADY;
   assign wr_last = (wr_cnt == wr_len);

   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) w_state <= W_IDLE;
      else             w_state <= w_state_nxt;
   end

   // The beat count alone ends the data phase; WLAST only feeds the error flag.
   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
         W_DATA:  if (w_fire && wr_last) w_state_nxt = W_RESP;
         W_RESP:  if (b_fire) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      regAWREADY = 1'b0;
      regWREADY  = 1'b0;
      regBVALID  = 1'b0;
      regBRESP   = RESP_OKAY;
      case (w_state)
         W_IDLE: regAWREADY = ready_en;
         W_DATA: regWREADY  = 1'b1;
         W_RESP: begin
            regBVALID = 1'b1;
            regBRESP  = wr_resp;
         end
         default: ;
      endcase
   end

   assign wr_oor      = !(wr_idx < NUM_REGS_IDX);
   assign wr_beat_err = wr_oor || (regWLAST != wr_last);

   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) begin
         wr_id    <= '0;
         wr_len   <= '0;
         wr_cnt   <= '0;
         wr_burst <= '0;
         wr_idx   <= '0;
         wr_err   <= 1'b0;
      end else if (aw_fire) begin
         wr_id    <= regAWID;
         wr_len   <= regAWLEN;
         wr_cnt   <= '0;
         wr_burst <= regAWBURST;
         wr_idx   <= regAWADDR[14:2];
         wr_err   <= 1'b0;
      end else if (w_fire) begin
         wr_err <= wr_err | wr_beat_err;
         if (!wr_last) begin
            wr_cnt <= wr_cnt + 8'd1;
            wr_idx <= next_idx(wr_idx, wr_burst);
         end
      end
   end

   assign regBID = wr_id;

   // ------------------------------------------------------------------ register bank
   always_ff @(posedge regACLK or negedge regARESETn) begin
      if (!regARESETn) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (w_fire && !wr_oor) begin
         for (int b = 0; b < 4; b++) begin
            if (regWSTRB[b]) regs[wr_idx[IW-1:0]][8*b +: 8] <= regWDATA[8*b +: 8];
         end
      end
   end

   // ------------------------------------------------------------------ response codes
`ifdef AXI_REG_RESPONDER_SLVERR_EN
   assign rd_load_resp = rd_load_oor ? RESP_SLVERR : RESP_OKAY;
   assign wr_resp      = wr_err ? RESP_SLVERR : RESP_OKAY;
   logic unused_err;
   assign unused_err = 1'b0;
`else
   assign rd_load_resp = RESP_OKAY;
   assign wr_resp      = RESP_OKAY;
   // Range and WLAST tracking still run but have no visible effect in this build.
   logic unused_err;
   assign unused_err = rd_load_oor ^ wr_err;
`endif

   // Beats are always whole words, so size and the byte offset are not used.
   logic unused_ports;
   assign unused_ports = ^{regARSIZE, regAWSIZE, regARADDR[1:0], regAWADDR[1:0]};

endmodule

// File: tb/tb_axi_reg_responder.sv
// tb_axi_reg_responder: scoreboard bench for axi_reg_responder (NUM_REGS = 64).
// Expected R beats and B responses are derived from a register model and queued when the
// address phase is driven, then popped and compared as the DUT presents them.
module tb_axi_reg_responder;

   localparam int         NREGS = 64;
   localparam logic [1:0] OKAY  = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] FIXED = 2'b00;
`ifdef AXI_REG_RESPONDER_SLVERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [14:0] araddr, awaddr;
   logic [5:0]  arid, awid, rid, bid;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [31:0] rdata, wdata;
   logic [3:0]  wstrb;

   always #5 clk = ~clk;

   axi_reg_responder #(.NUM_REGS(NREGS)) dut (
      .regACLK(clk), .regARESETn(rst_n),
      .regARADDR(araddr), .regARID(arid), .regARLEN(arlen), .regARSIZE(arsize),
      .regARBURST(arburst), .regARVALID(arvalid), .regARREADY(arready),
      .regRDATA(rdata), .regRID(rid), .regRRESP(rresp), .regRLAST(rlast),
      .regRVALID(rvalid), .regRREADY(rready),
      .regAWADDR(awaddr), .regAWID(awid), .regAWLEN(awlen), .regAWSIZE(awsize),
      .regAWBURST(awburst), .regAWVALID(awvalid), .regAWREADY(awready),
      .regWDATA(wdata), .regWSTRB(wstrb), .regWLAST(wlast), .regWVALID(wvalid),
      .regWREADY(wready),
      .regBID(bid), .regBRESP(bresp), .regBVALID(bvalid), .regBREADY(bready)
   );

   typedef struct packed {
      logic [31:0] dat;
      logic [5:0]  id;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   typedef struct packed {
      logic [5:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t      r_q[$];
   b_exp_t      b_q[$];
   logic [31:0] model [NREGS];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] step(input logic [12:0] idx, input logic [1:0] burst);
      if (burst == FIXED || idx == 13'h1FFF) return idx;
      return idx + 13'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
   endtask

   task automatic ar_hs(input logic [14:0] addr, input logic [5:0] id,
                        input logic [7:0] len, input logic [1:0] burst);
      int n;
      araddr = addr; arid = id; arlen = len; arburst = burst; arsize = 3'd2;
      arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin tick(); n++; end
      chk("ar_ready", 32'(arready), 32'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic rd(input logic [14:0] addr, input logic [5:0] id, input logic [7:0] len,
                     input logic [1:0] burst, input bit toggle);
      logic [12:0] idx;
      r_exp_t      e;
      int          got, cyc;
      idx = addr[14:2];
      for (int b = 0; b <= int'(len); b++) begin
         e.dat  = (idx < NREGS) ? model[idx[5:0]] : 32'h0;
         e.id   = id;
         e.resp = (idx < NREGS) ? OKAY : ERR_RESP;
         e.last = (b == int'(len));
         r_q.push_back(e);
         idx = step(idx, burst);
      end
      ar_hs(addr, id, len, burst);
      got = 0;
      cyc = 0;
      while (got <= int'(len) && cyc < 500) begin
         rready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (rvalid && r_q.size() > 0) begin
            e = r_q[0];
            if (rready) begin
               chk("rdata", rdata, e.dat);
               chk("rid",   32'(rid), 32'(e.id));
               chk("rresp", 32'(rresp), 32'(e.resp));
               chk("rlast", 32'(rlast), 32'(e.last));
               void'(r_q.pop_front());
               got++;
            end else begin
               chk("r_hold", rdata, e.dat);
               chk("r_hold_last", 32'(rlast), 32'(e.last));
            end
         end
         tick();
         cyc++;
      end
      rready = 1'b0;
      chk("r_beats", 32'(got), 32'(int'(len) + 1));
      chk("r_idle", 32'(rvalid), 32'd0);
   endtask

   // bad_last inverts WLAST on every beat, so the burst always carries a mismatch.
   task automatic wr(input logic [14:0] addr, input logic [5:0] id, input logic [7:0] len,
                     input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                     input bit bad_last);
      logic [12:0] idx;
      logic [31:0] d;
      b_exp_t      e;
      bit          err;
      int          n;
      idx = addr[14:2];
      err = bad_last;
      for (int b = 0; b <= int'(len); b++) begin
         d = base + 32'(b);
         if (idx < NREGS) begin
            for (int k = 0; k < 4; k++)
               if (strb[k]) model[idx[5:0]][8*k +: 8] = d[8*k +: 8];
         end else begin
            err = 1'b1;
         end
         idx = step(idx, burst);
      end
      e.id   = id;
      e.resp = err ? ERR_RESP : OKAY;
      b_q.push_back(e);

      awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = 3'd2;
      awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin tick(); n++; end
      chk("aw_ready", 32'(awready), 32'd1);
      tick();
      awvalid = 1'b0;

      for (int b = 0; b <= int'(len); b++) begin
         wdata  = base + 32'(b);
         wstrb  = strb;
         wlast  = bad_last ? (b != int'(len)) : (b == int'(len));
         wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin tick(); n++; end
         chk("w_ready", 32'(wready), 32'd1);
         tick();
      end
      wvalid = 1'b0;
      wlast  = 1'b0;

      bready = 1'b1;
      n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk("b_valid", 32'(bvalid), 32'd1);
      if (bvalid && b_q.size() > 0) begin
         e = b_q.pop_front();
         chk("bid",   32'(bid), 32'(e.id));
         chk("bresp", 32'(bresp), 32'(e.resp));
      end
      tick();
      bready = 1'b0;
      chk("b_idle", 32'(bvalid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got, cyc;
      araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      rready = 1'b0; bready = 1'b0;
      clear_model();

      // Reset state: every output low while reset is held and before the first clock.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_rvalid",  32'(rvalid),  32'd0);
      chk("rst_wready",  32'(wready),  32'd0);
      chk("rst_bvalid",  32'(bvalid),  32'd0);
      chk("rst_rdata",   rdata,        32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_arready", 32'(arready), 32'd0);
      tick();
      chk("post_arready", 32'(arready), 32'd1);
      chk("post_awready", 32'(awready), 32'd1);

      // Single write then read-back of the same word.
      wr(15'h0008, 6'd5, 8'd0, INCR, 32'hDEADBEEF, 4'hF, 1'b0);
      rd(15'h0008, 6'd5, 8'd0, INCR, 1'b0);

      // Fill regs 0..3, then a 4-beat INCR read with a stalling master.
      wr(15'h0000, 6'd1, 8'd3, INCR, 32'hA5000010, 4'hF, 1'b0);
      rd(15'h0000, 6'd2, 8'd3, INCR, 1'b1);

      // Byte strobes merge into an existing value.
      wr(15'h0010, 6'd3, 8'd0, INCR, 32'hFFFFFFFF, 4'hF, 1'b0);
      wr(15'h0010, 6'd3, 8'd0, INCR, 32'h11223344, 4'b0101, 1'b0);
      rd(15'h0010, 6'd4, 8'd0, INCR, 1'b0);

      // Burst running off the top of the bank.
      wr(15'h00F8, 6'd7, 8'd3, INCR, 32'h50000000, 4'hF, 1'b0);
      rd(15'h00F8, 6'd8, 8'd3, INCR, 1'b0);

      // FIXED burst keeps hitting one register.
      wr(15'h0020, 6'd10, 8'd2, FIXED, 32'h0BADF00D, 4'hF, 1'b0);
      rd(15'h0020, 6'd11, 8'd2, FIXED, 1'b1);

      // WLAST disagreeing with the beat count.
      wr(15'h0030, 6'd12, 8'd1, INCR, 32'hCAFE0000, 4'hF, 1'b1);
      rd(15'h0030, 6'd13, 8'd1, INCR, 1'b0);

      // Index saturates at the top instead of wrapping to register 0.
      rd(15'h7FFC, 6'd14, 8'd2, INCR, 1'b0);

      // Reset in the middle of an 8-beat read, with beat 2 on the bus.
      ar_hs(15'h0000, 6'd9, 8'd7, INCR);
      rready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 2 && cyc < 50) begin
         if (rvalid) got++;
         tick();
         cyc++;
      end
      chk("mid_rvalid", 32'(rvalid), 32'd1);
      rst_n = 1'b0;
      rready = 1'b0;
      #1;
      chk("mid_rst_rvalid",  32'(rvalid),  32'd0);
      chk("mid_rst_arready", 32'(arready), 32'd0);
      chk("mid_rst_rdata",   rdata,        32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rel_arready", 32'(arready), 32'd0);
      tick();
      chk("mid_post_arready", 32'(arready), 32'd1);
      clear_model();
      rd(15'h0000, 6'd15, 8'd3, INCR, 1'b0);
      rd(15'h0010, 6'd16, 8'd0, INCR, 1'b0);
      rd(15'h00F8, 6'd17, 8'd1, INCR, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_reg_responder.md
AXI_REG_RESPONDER -- requirements
Module: axi_reg_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 64, meaning the number of 32-bit registers (power of two, 4..256).
REQ-002 SHALL have these clock and reset ports:
- regACLK  in  1  sole clock.
- regARESETn  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have these read-address ports:
- regARADDR in 15 (byte address)
- regARID in 6
- regARLEN in 8
- regARSIZE in 3
- regARBURST in 2
- regARVALID in 1
- regARREADY out 1
REQ-004 SHALL have these read-data ports:
- regRDATA out 32
- regRID out 6
- regRRESP out 2
- regRLAST out 1
- regRVALID out 1
- regRREADY in 1
REQ-005 SHALL have these write-address ports:
- regAWADDR in 15
- regAWID in 6
- regAWLEN in 8
- regAWSIZE in 3
- regAWBURST in 2
- regAWVALID in 1
- regAWREADY out 1
REQ-006 SHALL have these write-data ports:
- regWDATA in 32
- regWSTRB in 4
- regWLAST in 1
- regWVALID in 1
- regWREADY out 1
REQ-007 SHALL have these write-response ports:
- regBID out 6
- regBRESP out 2
- regBVALID out 1
- regBREADY in 1

Function
REQ-008 SHALL implement the AXI3/4 responder (slave) for the config register bus, with independent read and write engines and one outstanding transaction per direction.
REQ-009 SHALL run a read FSM R_IDLE -> R_DATA -> R_IDLE: regARREADY=1 only in R_IDLE; AR handshake latches ID, LEN, BURST and word index ADDR[14:2]; R_DATA is entered on the next cycle.
REQ-010 SHALL, in R_DATA, hold regRVALID=1 with RDATA, RID and RRESP stable until regRREADY=1; each handshake advances the beat; regRLAST=1 on beat LEN; the handshake on the last beat returns the FSM to R_IDLE.
REQ-011 SHALL run a write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE: regAWREADY=1 only in W_IDLE; regWREADY=1 only in W_DATA; regBVALID=1 only in W_RESP, held until regBREADY.
REQ-012 SHALL, on each W handshake, update the bytes of the addressed register enabled by regWSTRB[i]; the W handshake on beat LEN moves the FSM to W_RESP regardless of regWLAST; a WLAST/count mismatch SHALL set the error flag for the burst.
REQ-013 SHALL advance the address per beat: INCR and WRAP (WRAP is treated as INCR) increment the word index by 1, saturating at 13 bits with no wrap to 0; FIXED holds the address; regxSIZE is ignored (beats are always 4 bytes).
REQ-014 SHALL treat a beat as in-range when its word index is < NUM_REGS; out-of-range reads return 0 and out-of-range writes are dropped.
REQ-015 SHALL give read/write precedence as follows: a write committed in cycle N is visible to any R beat whose data is loaded in cycle N+1 or later; the read and write engines never stall each other.
REQ-016 SHALL drive regRRESP/regBRESP as OKAY (2'b00) unless the SLVERR behaviour of REQ-020 applies.

Reset
REQ-017 SHALL, while regARESETn=0, immediately force both FSMs to idle and drive all outputs to 0, except that regARREADY and regAWREADY go to 1 on the first clock after deassertion.
REQ-018 SHALL clear all registers to 0 on reset; a reset during a burst abandons it with no response.

Configuration
REQ-019 SHALL compile the SLVERR feature in or out with macro AXI_REG_RESPONDER_SLVERR_EN.
REQ-020 SHALL, with AXI_REG_RESPONDER_SLVERR_EN defined, return RRESP=2'b10 on each out-of-range read beat and BRESP=2'b10 if any write beat of the burst was out of range or hit a WLAST mismatch.
REQ-021 SHALL, without AXI_REG_RESPONDER_SLVERR_EN, always return OKAY; the data behaviour of REQ-014 is unchanged.

Verification
REQ-022 SHALL cover a single write of addr 0x0008, data 0xDEADBEEF, WSTRB 4'hF, ID 5, followed by a read of the same address -> BRESP=0, BID=5, then RDATA=0xDEADBEEF, RLAST=1, RID=5.
REQ-023 SHALL cover an INCR read at 0x0000 with ARLEN=3, RREADY toggling 1/0 -> 4 beats returning regs 0..3, data held stable while stalled, RLAST only on the 4th beat.
REQ-024 SHALL cover a write of 0x11223344 with WSTRB 4'b0101 onto 0xFFFFFFFF -> readback 0xFF22FF44.
REQ-025 SHALL cover an INCR write at index 62 with AWLEN=3 and the macro defined -> regs 62 and 63 written, beats 3 and 4 dropped, BRESP=2'b10; with the macro undefined -> BRESP=0.
REQ-026 SHALL cover regARESETn asserted mid-read at beat 2 of 8 -> RVALID=0 at once, ARREADY=1 on the first clock after release, all registers read 0.
